// File: rtl/ysyx_22040365_ifu_pkg.sv
// Shared IFU definitions: FSM state encoding, default reset PC, NOP instruction
// and the decode-side fetch payload.
package ysyx_22040365_ifu_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_e;

  localparam logic [XLEN-1:0] DEF_RESET_PC = 64'h8000_0000;
  localparam logic [ILEN-1:0] DEF_NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return |pc[1:0];
  endfunction

endpackage

// File: rtl/ysyx_22040365_ifu.sv
// Instruction fetch unit: one outstanding request, redirect/kill handling, held decode output.
// Optional YSYX_22040365_IFU_ALIGN_CHK_EN: misaligned PCs yield a NOP flagged with inst_misalign.
module ysyx_22040365_ifu
  import ysyx_22040365_ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [ILEN-1:0] NOP_INST = DEF_NOP_INST
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_misalign
);

  ifu_state_e      state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] req_addr_n;
  logic            kill, kill_n;
  logic            req_valid_n;
  logic            inst_valid_n;
  logic            req_fire;
  logic            hold_req;
  fetch_pkt_t      pkt, pkt_n;
`ifdef YSYX_22040365_IFU_ALIGN_CHK_EN
  logic            misalign_n;
`endif

  assign req_fire = imem_req_valid && imem_req_ready;
  // An issued but not yet accepted request keeps its address and valid.
  assign hold_req = (state == REQ) && imem_req_valid && !imem_req_ready;

`ifdef YSYX_22040365_IFU_ALIGN_CHK_EN
  assign redirect_tgt = redirect_pc;
`else
  assign redirect_tgt = redirect_pc & ~XLEN'(3);
`endif

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    kill_n       = kill;
    pkt_n        = pkt;
`ifdef YSYX_22040365_IFU_ALIGN_CHK_EN
    misalign_n   = inst_misalign;
`endif
    case (state)
      IDLE: begin
        state_n = REQ;
        if (redirect_valid) pc_n = redirect_tgt;
      end
      REQ: begin
        if (redirect_valid) begin
          pc_n = redirect_tgt;
          if (imem_req_valid) kill_n = 1'b1;
        end
        if (req_fire) begin
          state_n = WAIT;
        end
`ifdef YSYX_22040365_IFU_ALIGN_CHK_EN
        else if (!imem_req_valid && !redirect_valid) begin
          state_n    = HOLD;
          pkt_n      = '{inst: NOP_INST, pc: pc};
          misalign_n = 1'b1;
        end
`endif
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_n   = redirect_tgt;
          kill_n = 1'b1;
        end
        if (imem_rsp_valid) begin
          kill_n = 1'b0;
          if (kill || redirect_valid) begin
            state_n = REQ;
          end else begin
            state_n = HOLD;
            pkt_n   = '{inst: imem_rsp_data, pc: pc};
`ifdef YSYX_22040365_IFU_ALIGN_CHK_EN
            misalign_n = 1'b0;
`endif
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_n    = redirect_tgt;
          state_n = REQ;
        end else if (inst_ready) begin
          pc_n    = pc + XLEN'(4);
          state_n = REQ;
        end
      end
      default: state_n = IDLE;
    endcase

    // Registered-output next values derived from the next state.
    req_valid_n = 1'b0;
    req_addr_n  = imem_req_addr;
    if (hold_req) begin
      req_valid_n = 1'b1;
    end else if (state_n == REQ) begin
      req_addr_n  = pc_n;
`ifdef YSYX_22040365_IFU_ALIGN_CHK_EN
      req_valid_n = !pc_misaligned(pc_n);
`else
      req_valid_n = 1'b1;
`endif
    end
    inst_valid_n = (state_n == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      kill           <= 1'b0;
      pkt            <= '{inst: NOP_INST, pc: '0};
      imem_req_valid <= 1'b0;
      imem_req_addr  <= RESET_PC;
      inst_valid     <= 1'b0;
`ifdef YSYX_22040365_IFU_ALIGN_CHK_EN
      inst_misalign  <= 1'b0;
`endif
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      kill           <= kill_n;
      pkt            <= pkt_n;
      imem_req_valid <= req_valid_n;
      imem_req_addr  <= req_addr_n;
      inst_valid     <= inst_valid_n;
`ifdef YSYX_22040365_IFU_ALIGN_CHK_EN
      inst_misalign  <= misalign_n;
`endif
    end
  end

  assign inst    = pkt.inst;
  assign inst_pc = pkt.pc;
`ifndef YSYX_22040365_IFU_ALIGN_CHK_EN
  assign inst_misalign = 1'b0;
`endif

endmodule
